prog_freq_divider: RTL and testbench

PROG_FREQ_DIVIDER -- requirements
Module: prog_freq_divider

---
 rtl/prog_freq_divider.sv | 143 ++++++++++++++
 tb/tb_prog_freq_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_freq_divider.sv
// prog_freq_divider: programmable integer clock divider.
//
// A counter runs 0..N-1 (N = div_cur) on enabled clock edges. The divided
// clock f_qn is low for floor(N/2) counts and high for the rest, and tick
// strobes once per output period. A new ratio can be requested at any time
// with div_load. It waits in a pending register and is applied only on the
// wrap edge, so the output never shows a runt or stretched period. A request
// with a ratio below 2 is rejected with a one-cycle div_err pulse.
//
// Build option: define ODD_DUTY50_EN to trim the high phase for odd N by
// half a clock, which gives 50% duty. It does this with a negedge recapture
// of the positive-edge output. Without the macro the design is purely
// posedge, and odd N gives one extra high cycle.
module prog_freq_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             f_qn,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV       = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE           = WIDTH'(1);

  // Architectural state.
  logic [WIDTH-1:0] cnt_reg,           cnt_next;
  logic [WIDTH-1:0] div_cur_reg,       div_cur_next;
  logic [WIDTH-1:0] pending_reg,       pending_next;
  logic             pending_valid_reg, pending_valid_next;
  logic             f_pos_reg,         f_pos_next;
  logic             tick_reg,          tick_next;
  logic             div_err_reg,       div_err_next;

  // Decoded helpers.
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] half_div;
  logic             wrap;
  logic             load_ok;
  logic             load_bad;

  // Decode the wrap point, the low-phase length and the load legality.
  always_comb begin
    last_cnt = div_cur_reg - ONE;
    cnt_inc  = cnt_reg + ONE;
    half_div = div_cur_reg >> 1;
    wrap     = (cnt_reg == last_cnt);
    load_ok  = div_load && (div_in >= MIN_DIV);
    load_bad = div_load && (div_in <  MIN_DIV);
  end

  // Next-state logic: advance the counter, swap ratios at the wrap, and
  // capture load requests.
  always_comb begin
    cnt_next           = cnt_reg;
    div_cur_next       = div_cur_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;
    f_pos_next         = f_pos_reg;
    tick_next          = 1'b0;
    div_err_next       = load_bad;

    if (en) begin
      tick_next = wrap;
      if (wrap) begin
        // The new period always starts at count 0. Count 0 lies in the low
        // phase for every legal N, so the output falls here no matter which
        // ratio is in force for the next period.
        cnt_next   = '0;
        f_pos_next = 1'b0;
        if (pending_valid_reg) begin
          div_cur_next       = pending_reg;
          pending_valid_next = 1'b0;
        end
      end else begin
        cnt_next   = cnt_inc;
        f_pos_next = (cnt_inc >= half_div);
      end
    end

    // A coincident load lands after any apply above. A request on the wrap
    // edge therefore stays pending for the following wrap, and a later
    // request overwrites an earlier one that has not been applied yet.
    if (load_ok) begin
      pending_next       = div_in;
      pending_valid_next = 1'b1;
    end
  end

  // State register: reset returns to the default ratio and drops any pending load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg           <= '0;
      div_cur_reg       <= DEFAULT_DIV_W;
      pending_reg       <= DEFAULT_DIV_W;
      pending_valid_reg <= 1'b0;
      f_pos_reg         <= 1'b0;
      tick_reg          <= 1'b0;
      div_err_reg       <= 1'b0;
    end else begin
      cnt_reg           <= cnt_next;
      div_cur_reg       <= div_cur_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
      f_pos_reg         <= f_pos_next;
      tick_reg          <= tick_next;
      div_err_reg       <= div_err_next;
    end
  end

`ifdef ODD_DUTY50_EN
  logic f_neg_reg;

  // Recapture the output half a cycle later. ANDing this copy with the
  // positive-edge output delays the rising edge by half a clock and leaves
  // the falling edge unchanged.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      f_neg_reg <= 1'b0;
    end else begin
      f_neg_reg <= f_pos_reg;
    end
  end

  // Odd ratios use the trimmed waveform. Even ratios are already symmetric.
  assign f_qn = div_cur_reg[0] ? (f_pos_reg & f_neg_reg) : f_pos_reg;
`else
  assign f_qn = f_pos_reg;
`endif

  assign tick    = tick_reg;
  assign div_cur = div_cur_reg;
  assign div_err = div_err_reg;

endmodule

// File: tb/tb_prog_freq_divider.sv
// tb_prog_freq_divider: scoreboard bench for prog_freq_divider.
//
// The driver applies one set of inputs per clock, at the negative edge. For
// each set it advances a behavioural model and pushes the expected outputs
// into a queue. The model builds each output period as a list of
// (f_qn, tick) samples, one per enabled edge, and consumes one sample per
// enabled edge. A separate monitor samples the DUT 1 time unit after each
// rising edge, pops the oldest expected entry and compares.
module tb_prog_freq_divider;

  localparam int WIDTH   = 8;
  localparam int DEF_DIV = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             f_qn;
  logic             tick;
  logic [WIDTH-1:0] div_cur;
  logic             div_err;

  prog_freq_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .f_qn     (f_qn),
    .tick     (tick),
    .div_cur  (div_cur),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit f;
    bit t;
    int d;
    bit e;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state.
  bit [1:0] pat_q[$];   // remaining {f, tick} samples of the current period
  int       m_ratio;
  int       m_pend;
  bit       m_pend_v;
  bit       m_f;
  bit       m_fprev;
  bit       m_tick;
  bit       m_err;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    pat_q.delete();
    m_ratio  = DEF_DIV;
    m_pend   = 0;
    m_pend_v = 1'b0;
    m_f      = 1'b0;
    m_fprev  = 1'b0;
    m_tick   = 1'b0;
    m_err    = 1'b0;
  endfunction

  // Advance the model by one rising clock edge.
  function automatic void model_edge(bit e, bit l, int d);
    bit [1:0] item;
    m_fprev = m_f;
    m_err   = l && (d < 2);
    m_tick  = 1'b0;
    if (e) begin
      if (pat_q.size() == 0) begin
        // A period of N edges. After edge k the output is high for
        // floor(N/2) <= k < N, and tick marks the final edge.
        for (int k = 1; k <= m_ratio; k++) begin
          pat_q.push_back({bit'((k < m_ratio) && (k >= m_ratio / 2)), bit'(k == m_ratio)});
        end
      end
      item   = pat_q.pop_front();
      m_f    = item[1];
      m_tick = item[0];
      if (pat_q.size() == 0 && m_pend_v) begin
        m_ratio  = m_pend;
        m_pend_v = 1'b0;
      end
    end
    if (l && d >= 2) begin
      m_pend   = d;
      m_pend_v = 1'b1;
    end
  endfunction

  function automatic bit exp_f();
`ifdef ODD_DUTY50_EN
    // At the sample point the negedge copy still holds the output from
    // before this edge.
    if (m_ratio % 2 == 1) return m_f & m_fprev;
`endif
    return m_f;
  endfunction

  task automatic step(bit r, bit e, bit l, int d);
    exp_t x;
    @(negedge clk);
    rst      = r;
    en       = e;
    div_load = l;
    div_in   = d[WIDTH-1:0];
    if (r) model_reset();
    else   model_edge(e, l, d);
    x.f = exp_f();
    x.t = m_tick;
    x.d = m_ratio;
    x.e = m_err;
    sb_q.push_back(x);
  endtask

  // Monitor: check every cycle that has an expectation queued.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        $display("cyc %0d rst=%0b en=%0b load=%0b din=%0d | f_qn=%0b tick=%0b div_cur=%0d div_err=%0b",
                 cyc, rst, en, div_load, div_in, f_qn, tick, div_cur, div_err);
        check("f_qn",    {31'd0, f_qn},    {31'd0, x.f});
        check("tick",    {31'd0, tick},    {31'd0, x.t});
        check("div_cur", {24'd0, div_cur}, x.d);
        check("div_err", {31'd0, div_err}, {31'd0, x.e});
      end
    end
  end

  // Watchdog: the run has a fixed number of steps, so this bound never
  // limits a healthy run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int  r;
    bit  re;
    bit  rl;
    int  rd;
    int  guard;

    rst      = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    model_reset();

    // Reset takes effect before any clock edge.
    #1;
    check("rst_f_qn",    {31'd0, f_qn},    0);
    check("rst_tick",    {31'd0, tick},    0);
    check("rst_div_err", {31'd0, div_err}, 0);
    check("rst_div_cur", {24'd0, div_cur}, DEF_DIV);

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Default N=2: the output toggles on every edge.
    repeat (6) step(0, 1, 0, 0);

    // Load 8 mid-period. The current N=2 period completes first.
    step(0, 1, 1, 8);
    repeat (20) step(0, 1, 0, 0);

    // N=5: odd ratio.
    step(0, 1, 1, 5);
    repeat (18) step(0, 1, 0, 0);

    // Rejected loads; ratio and period unchanged.
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    repeat (6) step(0, 1, 0, 0);

    // Two loads inside one period: only the last one is applied.
    guard = 0;
    while (!m_tick && guard < 20) begin
      step(0, 1, 0, 0);
      guard++;
    end
    check("wrap_found", {31'd0, m_tick}, 1);
    step(0, 1, 1, 6);
    step(0, 1, 1, 10);
    repeat (25) step(0, 1, 0, 0);

    // Enable low for 3 cycles mid-period.
    repeat (3) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);

    // Reset asserted during the high phase of N=8.
    step(0, 1, 1, 8);
    guard = 0;
    while (!(m_ratio == 8 && m_f) && guard < 40) begin
      step(0, 1, 0, 0);
      guard++;
    end
    check("high_phase_found", {31'd0, m_f}, 1);
    @(posedge clk);
    #2;
    check("pre_rst_f_qn", {31'd0, f_qn}, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_f_qn",    {31'd0, f_qn},    0);
    check("async_rst_tick",    {31'd0, tick},    0);
    check("async_rst_div_cur", {24'd0, div_cur}, DEF_DIV);
    model_reset();
    step(1, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      r  = $urandom_range(0, 99);
      re = ($urandom_range(0, 99) < 85);
      rl = ($urandom_range(0, 99) < 6);
      if (r < 15)      rd = $urandom_range(0, 1);
      else if (r < 97) rd = $urandom_range(2, 12);
      else             rd = $urandom_range(13, 40);
      step(($urandom_range(0, 199) == 0), re, rl, rd);
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
